// File: rtl/prbs31_checker.sv
// PRBS31 (x^31+x^28+1) receive checker: search, verify, lock and loss-of-lock.
// Define PRBS31_CHK_ERRCNT_EN to build the saturating err_count.
module prbs31_checker #(
  parameter int VERIFY_LEN = 64,
  parameter int LOSS_ERRS  = 8,
  parameter int LOSS_WIN   = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bit_in,
  input  logic        bit_valid,
  input  logic        clear_cnt,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_count,
  output logic [1:0]  state
);

  localparam int VW = $clog2(VERIFY_LEN + 1);
  localparam int WW = (LOSS_WIN > 1) ? $clog2(LOSS_WIN) : 1;
  localparam int EW = $clog2(LOSS_ERRS + 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e        st_q;
  logic [30:0]   s_q;
  logic [4:0]    ld_q;
  logic [VW-1:0] vcnt_q;
  logic [WW-1:0] win_q;
  logic [EW-1:0] werr_q;
  logic          locked_q;
  logic          pulse_q;

  logic        p;
  logic        mis;
  logic        win_wrap;
  logic [30:0] s_ld;
  logic [30:0] s_gen;

  assign p        = s_q[30] ^ s_q[27];
  assign mis      = bit_in ^ p;
  assign s_ld     = {s_q[29:0], bit_in};
  assign s_gen    = {s_q[29:0], p};
  assign win_wrap = (win_q == WW'(LOSS_WIN - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q     <= SEARCH;
      s_q      <= '0;
      ld_q     <= '0;
      vcnt_q   <= '0;
      win_q    <= '0;
      werr_q   <= '0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (bit_valid) begin
        case (st_q)
          SEARCH: begin
            s_q <= s_ld;
            if (ld_q == 5'd30) begin
              ld_q   <= '0;
              vcnt_q <= '0;
              st_q   <= VERIFY;
            end else begin
              ld_q <= ld_q + 5'd1;
            end
          end
          VERIFY: begin
            s_q <= s_ld;
            if (mis) begin
              st_q   <= SEARCH;
              ld_q   <= '0;
              vcnt_q <= '0;
            end else if (vcnt_q == VW'(VERIFY_LEN - 1)) begin
              vcnt_q <= '0;
              // an all-zero register would self-predict zeros forever
              if (s_ld == '0) begin
                st_q <= SEARCH;
                ld_q <= '0;
              end else begin
                st_q     <= LOCKED;
                win_q    <= '0;
                werr_q   <= '0;
                locked_q <= 1'b1;
              end
            end else begin
              vcnt_q <= vcnt_q + VW'(1);
            end
          end
          LOCKED: begin
            s_q     <= s_gen;
            pulse_q <= mis;
            win_q   <= win_wrap ? '0 : win_q + WW'(1);
            if (mis && (werr_q >= EW'(LOSS_ERRS - 1))) begin
              st_q     <= SEARCH;
              ld_q     <= '0;
              werr_q   <= '0;
              locked_q <= 1'b0;
            end else if (win_wrap) begin
              werr_q <= '0;
            end else if (mis) begin
              werr_q <= werr_q + EW'(1);
            end
          end
          default: begin
            st_q     <= SEARCH;
            ld_q     <= '0;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef PRBS31_CHK_ERRCNT_EN
  logic [15:0] cnt_q;
  logic        lk_err;

  assign lk_err = bit_valid && (st_q == LOCKED) && mis;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear_cnt) begin
      cnt_q <= '0;
    end else if (lk_err && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign err_count = cnt_q;
`else
  logic unused_clr;
  assign unused_clr = clear_cnt;
  assign err_count  = 16'h0000;
`endif

  assign locked    = locked_q;
  assign err_pulse = pulse_q;
  assign state     = st_q;

endmodule

// File: tb/tb_prbs31_checker.sv
// Bench for prbs31_checker: randomized PRBS31 streams vs a history-queue model.
// A second instance with a short window exercises err_count saturation.
module tb_prbs31_checker;

  logic        clk;
  logic        rst_n;
  logic        bit_in;
  logic        bit_valid;
  logic        clear_cnt;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [1:0]  state;

  logic        s_rst_n;
  logic        s_bit;
  logic        s_valid;
  logic        s_clr;
  logic        s_locked;
  logic        s_pulse;
  logic [15:0] s_count;
  logic [1:0]  s_state;

  int checks;
  int errors;
  int lk_cnt;
  int mcnt;
  int nv;
  logic b;
  logic hist[$];

  prbs31_checker u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .clear_cnt (clear_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .state     (state)
  );

  prbs31_checker #(
    .VERIFY_LEN (64),
    .LOSS_ERRS  (8),
    .LOSS_WIN   (4)
  ) u_sat (
    .clk       (clk),
    .rst_n     (s_rst_n),
    .bit_in    (s_bit),
    .bit_valid (s_valid),
    .clear_cnt (s_clr),
    .locked    (s_locked),
    .err_pulse (s_pulse),
    .err_count (s_count),
    .state     (s_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected err_count after n locked errors.
  function automatic logic [31:0] ec(input int n);
`ifdef PRBS31_CHK_ERRCNT_EN
    return (n > 65535) ? 32'hFFFF : 32'(n);
`else
    return 32'(n) & 32'h0;
`endif
  endfunction

  // Expected state after nv valid bits of a clean stream.
  function automatic logic [31:0] exp_st(input int n);
    if (n < 31) return 32'd0;
    if (n < 95) return 32'd1;
    return 32'd2;
  endfunction

  task automatic seed();
    hist.delete();
    repeat (31) hist.push_back(1'b1);
  endtask

  // b[n] = b[n-31] ^ b[n-28]
  task automatic next_bit(output logic nb);
    nb = hist[0] ^ hist[3];
    void'(hist.pop_front());
    hist.push_back(nb);
  endtask

  task automatic step(input logic bi, input logic v);
    bit_in    = bi;
    bit_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic sstep(input logic bi, input logic v);
    s_bit   = bi;
    s_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic lk_step(input logic flip);
    logic nb;
    next_bit(nb);
    step(nb ^ flip, 1'b1);
    lk_cnt++;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    lk_cnt    = 0;
    mcnt      = 0;
    rst_n     = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    clear_cnt = 1'b0;
    s_rst_n   = 1'b0;
    s_bit     = 1'b0;
    s_valid   = 1'b0;
    s_clr     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_pulse", 32'(err_pulse), 32'd0);
    chk("rst_count", 32'(err_count), 32'd0);

    // clean acquisition
    rst_n = 1'b1;
    seed();
    for (int n = 1; n <= 95; n++) begin
      next_bit(b);
      step(b, 1'b1);
      chk("acq_state", 32'(state), exp_st(n));
      chk("acq_locked", 32'(locked), 32'(n >= 95));
    end

    for (int n = 0; n < 10000; n++) begin
      lk_step(1'b0);
      chk("clean_pulse", 32'(err_pulse), 32'd0);
      chk("clean_locked", 32'(locked), 32'd1);
    end
    chk("clean_count", 32'(err_count), ec(0));

    // single error
    repeat ($urandom_range(1, 40)) lk_step(1'b0);
    lk_step(1'b1);
    mcnt = 1;
    chk("single_pulse", 32'(err_pulse), 32'd1);
    chk("single_count", 32'(err_count), ec(mcnt));
    chk("single_locked", 32'(locked), 32'd1);
    lk_step(1'b0);
    chk("single_pulse_end", 32'(err_pulse), 32'd0);

    // clear coincident with an error
    clear_cnt = 1'b1;
    lk_step(1'b1);
    clear_cnt = 1'b0;
    mcnt = 0;
    chk("clr_err_count", 32'(err_count), ec(mcnt));
    chk("clr_err_pulse", 32'(err_pulse), 32'd1);

    // loss of lock: 8 errors inside one aligned window
    lk_step(1'b0);
    while ((lk_cnt % 128) != 0) lk_step(1'b0);
    for (int k = 1; k <= 8; k++) begin
      repeat ($urandom_range(0, 14)) lk_step(1'b0);
      lk_step(1'b1);
      mcnt++;
      chk("loss_count", 32'(err_count), ec(mcnt));
      chk("loss_locked", 32'(locked), 32'(k < 8));
      chk("loss_state", 32'(state), (k < 8) ? 32'd2 : 32'd0);
    end
    for (int n = 0; n < 40; n++) begin
      step(1'($urandom), 1'b1);
      chk("search_pulse", 32'(err_pulse), 32'd0);
    end
    chk("held_count", 32'(err_count), ec(8));

    // all-zero stream never locks
    rst_n = 1'b0;
    step(1'b0, 1'b1);
    rst_n = 1'b1;
    for (int n = 0; n < 300; n++) begin
      step(1'b0, 1'b1);
      chk("zero_locked", 32'(locked), 32'd0);
      chk("zero_state_lk", 32'(state == 2'd2), 32'd0);
    end

    // gapped stream locks at the same valid-bit count
    rst_n = 1'b0;
    step(1'b0, 1'b1);
    rst_n = 1'b1;
    seed();
    nv = 0;
    for (int c = 0; c < 2000 && nv < 120; c++) begin
      if ($urandom_range(0, 1) == 1) begin
        next_bit(b);
        step(b, 1'b1);
        nv++;
      end else begin
        step(1'($urandom), 1'b0);
      end
      chk("gap_state", 32'(state), exp_st(nv));
      chk("gap_locked", 32'(locked), 32'(nv >= 95));
      chk("gap_pulse", 32'(err_pulse), 32'd0);
    end
    chk("gap_budget", 32'(nv >= 120), 32'd1);

    // reset mid-lock
    rst_n = 1'b0;
    next_bit(b);
    step(b, 1'b1);
    rst_n = 1'b1;
    chk("mrst_state", 32'(state), 32'd0);
    chk("mrst_locked", 32'(locked), 32'd0);
    chk("mrst_pulse", 32'(err_pulse), 32'd0);
    chk("mrst_count", 32'(err_count), 32'd0);
    seed();
    for (int n = 1; n <= 95; n++) begin
      next_bit(b);
      step(b, 1'b1);
      if (n >= 94) begin
        chk("relock_state", 32'(state), exp_st(n));
        chk("relock_locked", 32'(locked), 32'(n >= 95));
      end
    end
    bit_valid = 1'b0;

    // saturation on the short-window instance
    s_rst_n = 1'b1;
    seed();
    for (int n = 0; n < 95; n++) begin
      next_bit(b);
      sstep(b, 1'b1);
    end
    chk("sat_locked0", 32'(s_locked), 32'd1);
    for (int n = 0; n < 65535; n++) begin
      next_bit(b);
      sstep(~b, 1'b1);
    end
    chk("sat_65535", 32'(s_count), ec(65535));
    chk("sat_locked1", 32'(s_locked), 32'd1);
    next_bit(b);
    sstep(~b, 1'b1);
    chk("sat_65536", 32'(s_count), ec(65536));
    chk("sat_pulse", 32'(s_pulse), 32'd1);
    s_clr = 1'b1;
    next_bit(b);
    sstep(b, 1'b1);
    s_clr = 1'b0;
    chk("sat_clear", 32'(s_count), 32'd0);
    s_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
